// File: rtl/gcm_rx_verify_if.sv
// Core-side and downstream signals of the GCM receive release gate.
// The master drives the i_* signals; the slave (the gate) drives the o_* signals.
interface gcm_rx_verify_if #(
    parameter int BYPASS_W = 289
);
    logic                i_new;
    logic                i_cp_ready;
    logic [0:127]        i_plain_text;
    logic [BYPASS_W-1:0] i_bypass_text;
    logic                i_tag_ready;
    logic [0:127]        i_tag;
    logic [0:127]        i_rx_tag;
    logic                i_out_ready;
    logic                o_valid;
    logic [0:127]        o_plain_text;
    logic [BYPASS_W-1:0] o_bypass_text;
    logic                o_auth_ok;
    logic                o_auth_fail;
    logic                o_done;
    logic                o_busy;

    modport master (
        output i_new, i_cp_ready, i_plain_text, i_bypass_text,
               i_tag_ready, i_tag, i_rx_tag, i_out_ready,
        input  o_valid, o_plain_text, o_bypass_text,
               o_auth_ok, o_auth_fail, o_done, o_busy
    );

    modport slave (
        input  i_new, i_cp_ready, i_plain_text, i_bypass_text,
               i_tag_ready, i_tag, i_rx_tag, i_out_ready,
        output o_valid, o_plain_text, o_bypass_text,
               o_auth_ok, o_auth_fail, o_done, o_busy
    );
endinterface

// File: rtl/gcm_rx_verify.sv
// Receive-side release gate for AES-GCM: buffers decrypted blocks until the tag
// check resolves, then releases them on a match or drops them on a mismatch.
//
// state   | meaning
// IDLE    | no message; block and tag strobes ignored
// COLLECT | buffering blocks, waiting for the tag compare
// RELEASE | tag matched; draining the FIFO downstream
module gcm_rx_verify #(
    parameter int DEPTH    = 4,
    parameter int BYPASS_W = 289
) (
    input  logic            clk,
    input  logic            rst_n,
    gcm_rx_verify_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, RELEASE} state_t;

    state_t              state_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                ovf_q;
    logic                auth_ok_q;
    logic                auth_fail_q;
    logic                done_q;

    logic [0:127]        mem_pt_q [DEPTH];
    logic [BYPASS_W-1:0] mem_bp_q [DEPTH];

    logic                collect;
    logic                has_room;
    logic                wr_en;
    logic [PW-1:0]       wr_idx;
    logic                ovf_hit;
    logic                xfer;
    logic                tags_eq;
    logic [CW-1:0]       cnt_after_wr;
    logic                rd_valid;

    assign collect      = (state_q == COLLECT);
    assign has_room     = (count_q != CNT_MAX);
    // A block arriving with i_new becomes entry 0 of the new message.
    assign wr_en        = bus.i_cp_ready && (bus.i_new || (collect && has_room));
    assign wr_idx       = bus.i_new ? '0 : wr_ptr_q;
    assign ovf_hit      = collect && bus.i_cp_ready && !has_room && !bus.i_new;
    assign rd_valid     = (state_q == RELEASE) && (count_q != '0);
    assign xfer         = rd_valid && bus.i_out_ready;
    assign tags_eq      = (bus.i_tag == bus.i_rx_tag);
    assign cnt_after_wr = wr_en ? count_q + CNT_ONE : count_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pt_q[wr_idx] <= bus.i_plain_text;
            mem_bp_q[wr_idx] <= bus.i_bypass_text;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            auth_ok_q   <= 1'b0;
            auth_fail_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            auth_ok_q   <= 1'b0;
            auth_fail_q <= 1'b0;
            done_q      <= 1'b0;
            if (bus.i_new) begin
                state_q  <= COLLECT;
                rd_ptr_q <= '0;
                ovf_q    <= 1'b0;
                wr_ptr_q <= bus.i_cp_ready ? PTR_ONE : '0;
                count_q  <= bus.i_cp_ready ? CNT_ONE : '0;
            end else begin
                case (state_q)
                    COLLECT: begin
                        if (wr_en) begin
                            wr_ptr_q <= wr_ptr_q + PTR_ONE;
                            count_q  <= cnt_after_wr;
                        end
                        if (ovf_hit) ovf_q <= 1'b1;
                        if (bus.i_tag_ready) begin
                            if (tags_eq && !ovf_q && !ovf_hit) begin
                                auth_ok_q <= 1'b1;
                                if (cnt_after_wr == '0) begin
                                    done_q  <= 1'b1;
                                    state_q <= IDLE;
                                end else begin
                                    state_q <= RELEASE;
                                end
                            end else begin
                                auth_fail_q <= 1'b1;
                                wr_ptr_q    <= '0;
                                rd_ptr_q    <= '0;
                                count_q     <= '0;
                                ovf_q       <= 1'b0;
                                state_q     <= IDLE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (xfer) begin
                            rd_ptr_q <= rd_ptr_q + PTR_ONE;
                            count_q  <= count_q - CNT_ONE;
                            if (count_q == CNT_ONE) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Data is forced to zero whenever nothing is offered so stale or
    // unauthenticated entries are never visible on the output.
    assign bus.o_valid       = rd_valid;
    assign bus.o_plain_text  = rd_valid ? mem_pt_q[rd_ptr_q] : '0;
    assign bus.o_bypass_text = rd_valid ? mem_bp_q[rd_ptr_q] : '0;
    assign bus.o_auth_ok     = auth_ok_q;
    assign bus.o_auth_fail   = auth_fail_q;
    assign bus.o_done        = done_q;
    assign bus.o_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_gcm_rx_verify.sv
// Directed bench for gcm_rx_verify: expectations are queued as stimulus is
// issued and a negedge monitor pops and compares every observed event.
module tb_gcm_rx_verify;
    localparam int BW = 289;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcm_rx_verify_if #(.BYPASS_W(BW)) bus();

    gcm_rx_verify #(.DEPTH(4), .BYPASS_W(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int K_OK = 0, K_FAIL = 1, K_XFER = 2, K_DONE = 3;

    typedef struct {
        int         kind;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [0:127] blk(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [BW-1:0] bp(input logic [7:0] b);
        logic [295:0] r;
        r = {37{b ^ 8'hC3}};
        return r[BW-1:0];
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_OK:    return "auth_ok";
            K_FAIL:  return "auth_fail";
            K_XFER:  return "xfer";
            default: return "done";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input logic [7:0] b);
        exp_t e;
        e.kind = kind;
        e.b    = b;
        q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [0:127] pt, input logic [BW-1:0] bt);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s (data %h) expected nothing at %0t", kname(kind), pt, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                n_fail++;
                $display("FAIL event_kind: got %s expected %s at %0t", kname(kind), kname(e.kind), $time);
            end else if (kind == K_XFER && (pt != blk(e.b) || bt != bp(e.b))) begin
                n_fail++;
                $display("FAIL xfer_data: got %h / %h expected %h / %h at %0t", pt, bt, blk(e.b), bp(e.b), $time);
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one event per output per cycle, sampled at the falling edge.
    logic            stall_prev = 1'b0;
    logic [0:127]    prev_pt;
    logic [BW-1:0]   prev_bt;
    always @(negedge clk) begin
        if (stall_prev && bus.o_valid) begin
            n_cmp++;
            if (bus.o_plain_text != prev_pt || bus.o_bypass_text != prev_bt) begin
                n_fail++;
                $display("FAIL stall_hold: got %h expected %h at %0t", bus.o_plain_text, prev_pt, $time);
            end
        end
        if (bus.o_auth_ok)   observe(K_OK, '0, '0);
        if (bus.o_auth_fail) observe(K_FAIL, '0, '0);
        if (bus.o_valid && bus.i_out_ready) observe(K_XFER, bus.o_plain_text, bus.o_bypass_text);
        if (bus.o_done)      observe(K_DONE, '0, '0);
        stall_prev = bus.o_valid && !bus.i_out_ready;
        prev_pt    = bus.o_plain_text;
        prev_bt    = bus.o_bypass_text;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_msg();
        bus.i_new = 1'b1;
        step();
        bus.i_new = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] b);
        bus.i_cp_ready    = 1'b1;
        bus.i_plain_text  = blk(b);
        bus.i_bypass_text = bp(b);
        step();
        bus.i_cp_ready    = 1'b0;
    endtask

    // Tag strobe, optionally with a block in the same cycle; bit 127 flipped on mismatch.
    task automatic send_tag(input bit match, input bit with_blk, input logic [7:0] b);
        logic [0:127] rx;
        rx = {16{8'hAB}};
        if (!match) rx[127] = ~rx[127];
        bus.i_tag_ready = 1'b1;
        bus.i_tag       = {16{8'hAB}};
        bus.i_rx_tag    = rx;
        if (with_blk) begin
            bus.i_cp_ready    = 1'b1;
            bus.i_plain_text  = blk(b);
            bus.i_bypass_text = bp(b);
        end
        step();
        bus.i_tag_ready = 1'b0;
        bus.i_cp_ready  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) step();
        chk({name, "_drain_left"}, 128'(q.size()), 128'd0);
        q.delete();
        repeat (3) step();
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_valid"}, 128'(bus.o_valid), 128'd0);
        chk({name, "_busy"}, 128'(bus.o_busy), 128'd0);
        chk({name, "_pulses"}, 128'({bus.o_auth_ok, bus.o_auth_fail, bus.o_done}), 128'd0);
        chk({name, "_data"}, 128'(bus.o_plain_text), 128'd0);
    endtask

    initial begin
        bus.i_new = 1'b0;
        bus.i_cp_ready = 1'b0;
        bus.i_plain_text = '0;
        bus.i_bypass_text = '0;
        bus.i_tag_ready = 1'b0;
        bus.i_tag = '0;
        bus.i_rx_tag = '0;
        bus.i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Pass, 2 blocks
        new_msg();
        send_block(8'h11);
        send_block(8'h22);
        expect_ev(K_OK, 0); expect_ev(K_XFER, 8'h11); expect_ev(K_XFER, 8'h22); expect_ev(K_DONE, 0);
        send_tag(1, 0, 0);
        @(negedge clk);
        chk("pass_ok_k1", 128'(bus.o_auth_ok), 128'd1);
        chk("pass_valid_k1", 128'(bus.o_valid), 128'd1);
        drain("pass");
        chk("pass_busy_after", 128'(bus.o_busy), 128'd0);

        // Fail: rx tag differs in bit 127
        new_msg();
        send_block(8'h11);
        send_block(8'h22);
        expect_ev(K_FAIL, 0);
        send_tag(0, 0, 0);
        @(negedge clk);
        chk("fail_pulse_k1", 128'(bus.o_auth_fail), 128'd1);
        chk("fail_busy_k1", 128'(bus.o_busy), 128'd0);
        drain("fail");

        // Overflow: five blocks into a four-deep buffer
        new_msg();
        for (int i = 1; i <= 5; i++) send_block(8'(8'h50 + i));
        expect_ev(K_FAIL, 0);
        send_tag(1, 0, 0);
        @(negedge clk);
        chk("ovf_fail_k1", 128'(bus.o_auth_fail), 128'd1);
        drain("ovf");

        // Backpressure with the third block arriving alongside the tag
        new_msg();
        send_block(8'h41);
        send_block(8'h42);
        expect_ev(K_OK, 0); expect_ev(K_XFER, 8'h41); expect_ev(K_XFER, 8'h42);
        expect_ev(K_XFER, 8'h43); expect_ev(K_DONE, 0);
        send_tag(1, 1, 8'h43);
        bus.i_out_ready = 1'b1; step();
        bus.i_out_ready = 1'b0; step();
        bus.i_out_ready = 1'b0; step();
        bus.i_out_ready = 1'b1; step();
        bus.i_out_ready = 1'b1; step();
        @(negedge clk);
        chk("bp_done", 128'(bus.o_done), 128'd1);
        drain("bp");

        // Abort during release with two blocks left, then a clean pass
        new_msg();
        send_block(8'h31);
        send_block(8'h32);
        expect_ev(K_OK, 0); expect_ev(K_XFER, 8'h31);
        send_tag(1, 1, 8'h33);
        bus.i_out_ready = 1'b1; step();
        bus.i_out_ready = 1'b0;
        new_msg();
        @(negedge clk);
        chk("abort_valid", 128'(bus.o_valid), 128'd0);
        chk("abort_busy", 128'(bus.o_busy), 128'd1);
        bus.i_out_ready = 1'b1;
        send_block(8'h11);
        send_block(8'h22);
        expect_ev(K_OK, 0); expect_ev(K_XFER, 8'h11); expect_ev(K_XFER, 8'h22); expect_ev(K_DONE, 0);
        send_tag(1, 0, 0);
        drain("abort");

        // Asynchronous reset mid-collect, then an empty authenticated message
        new_msg();
        send_block(8'h61);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();
        new_msg();
        expect_ev(K_OK, 0); expect_ev(K_DONE, 0);
        send_tag(1, 0, 0);
        @(negedge clk);
        chk("empty_ok_done", 128'({bus.o_auth_ok, bus.o_done}), 128'd3);
        chk("empty_valid", 128'(bus.o_valid), 128'd0);
        drain("empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gcm_rx_verify.md
# gcm_rx_verify

Receive-side release gate for AES-GCM decryption. Accepts decrypted 128-bit blocks, each with its bypass word, from the GCM core. Holds every block in a small FIFO until the core's computed tag has been compared with the tag received alongside the ciphertext. On a match it releases the blocks downstream with a valid/ready handshake. On a mismatch it discards them, so unauthenticated plaintext never leaves the block.

## Interface
- DEPTH, 4, max blocks per message buffered (power of two, ≥2)
- BYPASS_W, 289, width of bypass word carried with each block
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_new  in  1  start new message; aborts any message in progress
- i_cp_ready  in  1  i_plain_text/i_bypass_text valid this cycle
- i_plain_text  in  [0:127]  decrypted block from core
- i_bypass_text  in  [BYPASS_W-1:0]  sideband travelling with block
- i_tag_ready  in  1  single-cycle pulse: i_tag and i_rx_tag valid
- i_tag  in  [0:127]  tag computed by core over ciphertext
- i_rx_tag  in  [0:127]  tag received with message
- i_out_ready  in  1  downstream accepts o_plain_text this cycle
- o_valid  out  1  o_plain_text/o_bypass_text hold a released block
- o_plain_text  out  [0:127]  released block
- o_bypass_text  out  [BYPASS_W-1:0]  released sideband
- o_auth_ok  out  1  one-cycle pulse: tags matched
- o_auth_fail  out  1  one-cycle pulse: mismatch or overflow
- o_done  out  1  one-cycle pulse: last block of authenticated message transferred
- o_busy  out  1  state ≠ IDLE

## Operation
- The FSM has three states: IDLE, COLLECT, RELEASE. Reset enters IDLE. Reset also clears both FIFO pointers, the count and the overflow flag. Every output resets to 0.
- **IDLE**
  - i_cp_ready and i_tag_ready are ignored.
  - i_new → COLLECT.
- **COLLECT**
  - i_cp_ready with count<DEPTH: write block and bypass at wr_ptr; wr_ptr+1 mod DEPTH; count+1.
  - i_cp_ready with count==DEPTH: block is discarded and the sticky overflow flag is set.
  - i_tag_ready with tags equal (full 128-bit compare) and no overflow: o_auth_ok pulses; go to RELEASE. If count==0, o_done pulses in the same cycle as o_auth_ok and the FSM returns to IDLE instead.
  - i_tag_ready with tags unequal or overflow set: o_auth_fail pulses; FIFO flushed (pointers, count, overflow cleared); go to IDLE.
- **RELEASE**
  - o_valid = (count>0). o_plain_text and o_bypass_text show mem[rd_ptr] (show-ahead).
  - Transfer happens when o_valid && i_out_ready: rd_ptr+1 mod DEPTH; count−1.
  - Transfer of the final block (count 1→0): o_done pulses next cycle; go to IDLE.
  - i_cp_ready and i_tag_ready are ignored.
  - o_valid holds and the data stays stable while i_out_ready=0.
- **Simultaneous events**
  - i_cp_ready and i_tag_ready in the same COLLECT cycle: the block is written first and is counted in the release (it also counts toward overflow).
  - i_new in any state: the FIFO is flushed and the overflow flag cleared; go to COLLECT. No pulse is produced for the aborted message. If i_cp_ready is also high, that block is written as entry 0 of the new message.
  - i_new overrides i_tag_ready in the same cycle.
- The count register is clog2(DEPTH+1) bits wide. Pointers are clog2(DEPTH) bits wide and wrap naturally.

## Timing
- Write: block is present at edge k; it is stored at edge k, and count is updated after edge k.
- Tag compare: i_tag_ready at edge k. Then o_auth_ok or o_auth_fail =1 during cycle k+1, and the state has changed by cycle k+1.
- First release: o_valid=1 during cycle k+1 (the same cycle as o_auth_ok), with zero-wait throughput of one block per cycle.
- o_done =1 during the cycle after the final transfer edge; o_busy=0 from that same cycle.
- Every pulse output is registered and is exactly one cycle wide.
- Asynchronous reset mid-RELEASE: o_valid drops immediately and remaining blocks are lost.

## Test plan
- **Pass, 2 blocks:** i_new; blocks 0x11…11 and 0x22…22; i_tag=i_rx_tag=0xAB…AB; i_out_ready=1 → o_auth_ok at k+1; o_valid for 2 cycles, outputs 0x11…11 then 0x22…22; o_done next cycle.
- **Fail:** same 2 blocks, i_rx_tag differs in bit 127 → o_auth_fail pulse; o_valid never asserts; o_busy=0 next cycle.
- **Overflow:** DEPTH=4; 5 blocks, then matching tags → o_auth_fail; no output.
- **Backpressure + simultaneous:** 3rd block arrives with i_tag_ready; i_out_ready toggles 1,0,0,1,1 → 3 blocks released in order; data stable during stalls; o_done after the 3rd transfer.
- **Abort:** i_new during RELEASE with 2 blocks left → o_valid=0 next cycle; the new message behaves as in the pass case.
- **Reset/empty:** rst_n low mid-COLLECT → all outputs 0; then i_new and matching tag with 0 blocks → o_auth_ok and o_done in the same cycle; o_valid stays 0.
